// File: rtl/pwm_decoder.sv
// PWM duty decoder: each rising edge opens a 256-cycle window whose high count becomes the
// sample; a line with no rising edge for TIMEOUT cycles is reported as 0 or 255.
module pwm_decoder #(
   parameter int unsigned TIMEOUT = 512
) (
   input  logic       clk,
   input  logic       n_rst,
   input  logic       pwm_i,
   output logic [7:0] sample,
   output logic       sample_valid,
   output logic       timeout
);

   typedef enum logic {StHunt, StMeasure} state_e;

   localparam logic [9:0] IdleLast = 10'(TIMEOUT - 1);

   state_e     state;
   logic       pwm_meta;
   logic       pwm_s;
   logic       pwm_d;
   logic       rise;
   logic [7:0] win_cnt;
   logic [8:0] hi_cnt;
   logic [9:0] idle_cnt;
   logic [8:0] final_sum;
   logic [7:0] final_sat;

   // A line held high for the whole window counts 256, which saturates to 255.
   always_comb begin
      rise      = pwm_s & ~pwm_d;
      final_sum = hi_cnt + {8'd0, pwm_s};
      final_sat = final_sum[8] ? 8'hff : final_sum[7:0];
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         pwm_meta     <= 1'b0;
         pwm_s        <= 1'b0;
         pwm_d        <= 1'b0;
         state        <= StHunt;
         win_cnt      <= 8'd0;
         hi_cnt       <= 9'd0;
         idle_cnt     <= 10'd0;
         sample       <= 8'd0;
         sample_valid <= 1'b0;
         timeout      <= 1'b0;
      end else begin
         pwm_meta     <= pwm_i;
         pwm_s        <= pwm_meta;
         pwm_d        <= pwm_s;
         sample_valid <= 1'b0;
         case (state)
            StHunt: begin
               if (rise) begin
                  // The rise cycle is window offset 0 and already counts as high.
                  state    <= StMeasure;
                  win_cnt  <= 8'd1;
                  hi_cnt   <= 9'd1;
                  idle_cnt <= 10'd0;
                  timeout  <= 1'b0;
               end else if (idle_cnt == IdleLast) begin
                  sample       <= {8{pwm_s}};
                  sample_valid <= 1'b1;
                  timeout      <= 1'b1;
                  idle_cnt     <= 10'd0;
               end else begin
                  idle_cnt <= idle_cnt + 10'd1;
               end
            end
            StMeasure: begin
               if (win_cnt == 8'd255) begin
                  state        <= StHunt;
                  sample       <= final_sat;
                  sample_valid <= 1'b1;
                  win_cnt      <= 8'd0;
                  hi_cnt       <= 9'd0;
               end else begin
                  win_cnt <= win_cnt + 8'd1;
                  hi_cnt  <= hi_cnt + {8'd0, pwm_s};
               end
            end
            default: state <= StHunt;
         endcase
      end
   end

endmodule

// File: tb/tb_pwm_decoder.sv
// Scoreboard bench for pwm_decoder: a waveform-level model predicts every sample_valid event and
// the timeout level; a negedge monitor pops and compares whatever the DUT presents.
module tb_pwm_decoder;

   localparam int Tmo    = 512;
   localparam int MaxLen = 4096;

   logic       clk = 1'b0;
   logic       n_rst;
   logic       pwm_i;
   logic [7:0] sample;
   logic       sample_valid;
   logic       timeout;

   pwm_decoder #(.TIMEOUT(Tmo)) dut (
      .clk          (clk),
      .n_rst        (n_rst),
      .pwm_i        (pwm_i),
      .sample       (sample),
      .sample_valid (sample_valid),
      .timeout      (timeout)
   );

   always #5 clk = ~clk;

   typedef struct {
      int at_cyc;
      int val;
   } ev_t;

   ev_t exp_q[$];
   bit  w[MaxLen];
   bit  to_exp[MaxLen];
   int  wlen;
   int  cyc;
   bit  active;
   int  last_exp;
   int  n_pass;
   int  n_checks;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
      n_checks++;
      if (act === exp_v) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp_v, cyc);
   endtask

   // Line level as seen by the decoder at edge t: two clocks of synchronizer delay.
   function automatic bit s_at(input int t);
      return (t >= 2) ? w[t-2] : 1'b0;
   endfunction

   // Walk the waveform: a rising edge opens a 256-cycle window whose high count (capped at
   // 255) is reported at its last cycle; otherwise TIMEOUT quiet cycles give a 0/255 report.
   function automatic void model(input int len);
      int t;
      int h;
      int sum;
      bit to;
      t  = 0;
      h  = 0;
      to = 1'b0;
      exp_q.delete();
      while (t < len) begin
         if (s_at(t) && !s_at(t - 1)) begin
            to = 1'b0;
            for (int k = 0; k < 256; k++) if (t + k < len) to_exp[t+k] = 1'b0;
            if (t + 255 >= len) break;
            sum = 0;
            for (int k = 0; k < 256; k++) sum += int'(s_at(t + k));
            exp_q.push_back('{at_cyc: t + 255, val: (sum > 255) ? 255 : sum});
            t += 256;
            h = t;
         end else if (t == h + Tmo - 1) begin
            to        = 1'b1;
            to_exp[t] = 1'b1;
            exp_q.push_back('{at_cyc: t, val: s_at(t) ? 255 : 0});
            h = t + 1;
            t++;
         end else begin
            to_exp[t] = to;
            t++;
         end
      end
   endfunction

   always @(negedge clk) begin
      if (active && cyc >= 0) begin
         if (sample_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_valid", 32'(sample_valid), 0);
            end else begin
               ev_t e;
               e = exp_q.pop_front();
               chk("valid_time", cyc, e.at_cyc);
               chk("sample", 32'(sample), e.val);
               last_exp = e.val;
            end
         end else begin
            chk("sample_hold", 32'(sample), last_exp);
         end
         chk("timeout", 32'(timeout), 32'(to_exp[cyc]));
      end
   end

   task automatic wave_clear();
      wlen = 0;
   endtask

   task automatic add_frame(input int n);
      for (int i = 0; i < 256; i++) w[wlen+i] = (i < n);
      wlen += 256;
   endtask

   task automatic add_level(input bit v, input int n);
      for (int i = 0; i < n; i++) w[wlen+i] = v;
      wlen += n;
   endtask

   // Release reset, play w[0..len-1], then assert reset asynchronously and check it clears.
   task automatic run_scen(input int len);
      model(len);
      last_exp = 0;
      repeat (2) @(negedge clk);
      #1;
      pwm_i  = w[0];
      cyc    = -1;
      active = 1'b1;
      n_rst  = 1'b1;
      for (int t = 0; t < len; t++) begin
         @(posedge clk);
         cyc = t;
         @(negedge clk);
         pwm_i = (t + 1 < len) ? w[t+1] : 1'b0;
      end
      #1;
      active = 1'b0;
      chk("pending_events", exp_q.size(), 0);
      n_rst = 1'b0;
      #1;
      chk("rst_sample", 32'(sample), 0);
      chk("rst_valid", 32'(sample_valid), 0);
      chk("rst_timeout", 32'(timeout), 0);
   endtask

   initial begin
      int n;
      int start;
      int plen;
      int pos;
      n_checks = 0;
      n_pass   = 0;
      active   = 1'b0;
      cyc      = -1;
      pwm_i    = 1'b0;
      n_rst    = 1'b1;
      #1 n_rst = 1'b0;
      #1;
      chk("init_sample", 32'(sample), 0);
      chk("init_valid", 32'(sample_valid), 0);
      chk("init_timeout", 32'(timeout), 0);

      // Three frames of duty 128.
      wave_clear();
      repeat (3) add_frame(128);
      add_level(1'b0, 10);
      run_scen(wlen);

      // Boundary duties back to back.
      wave_clear();
      add_frame(1);
      add_frame(255);
      add_frame(1);
      add_level(1'b0, 6);
      run_scen(wlen);

      // Idle low: repeated timeouts, then a frame of 40.
      wave_clear();
      add_level(1'b0, 1200);
      add_frame(40);
      add_level(1'b0, 4);
      run_scen(wlen);

      // Held high: saturated window then timeouts reporting 255.
      wave_clear();
      add_level(1'b1, 1400);
      run_scen(wlen);

      // Glitch inside the window must add high time, not restart.
      wave_clear();
      add_frame(100);
      for (int i = 200; i < 203; i++) w[i] = 1'b1;
      add_frame(100);
      add_level(1'b0, 4);
      run_scen(wlen);

      // Reset at offset 150 of the second window, then a fresh frame starting high.
      wave_clear();
      add_frame(60);
      add_frame(60);
      run_scen(409);
      wave_clear();
      add_frame(60);
      add_frame(60);
      add_level(1'b0, 4);
      run_scen(wlen);

      // Random duties, glitches and gaps.
      repeat (2) begin
         wave_clear();
         for (int f = 0; f < 7; f++) begin
            n     = $urandom_range(0, 255);
            start = wlen;
            add_frame(n);
            if (n < 240 && $urandom_range(0, 1) == 1) begin
               plen = $urandom_range(1, 3);
               pos  = $urandom_range(n + 2, 250);
               for (int j = 0; j < plen; j++) w[start+pos+j] = 1'b1;
            end
            if ($urandom_range(0, 3) == 0) add_level(1'b0, $urandom_range(1, 20));
            if (f == 3 && $urandom_range(0, 1) == 1) add_level(1'b0, $urandom_range(520, 700));
         end
         add_level(1'b0, 4);
         run_scen(wlen);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, got cycle %0d, expected completion", cyc);
      $fatal(1);
   end

endmodule
